conv1_ctrl: RTL and testbench

CONV1_CTRL -- requirements
Module: conv1_ctrl

---
 rtl/conv1_ctrl_if.sv | 27 ++
 rtl/conv1_ctrl.sv | 59 +++++
 tb/tb_conv1_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/conv1_ctrl_if.sv
// conv1_ctrl_if: frame control, parameter write, image fetch and datapath operand bundle
interface conv1_ctrl_if;
    logic         start;
    logic         prm_we;
    logic [4:0]   prm_addr;
    logic [15:0]  prm_wdata;
    logic         img_rd;
    logic [4:0]   img_addr;
    logic [223:0] img_rdata;
    logic         dp_rst;
    logic [223:0] pic_data;
    logic [47:0]  filt;
    logic [15:0]  bias;
    logic         busy;
    logic         done;
    logic         conv_vld;
    logic [4:0]   conv_row;
    logic         conv_sel;
    modport slave (
        input  start, prm_we, prm_addr, prm_wdata, img_rdata,
        output img_rd, img_addr, dp_rst, pic_data, filt, bias, busy, done, conv_vld, conv_row, conv_sel
    );
    modport master (
        output start, prm_we, prm_addr, prm_wdata, img_rdata,
        input  img_rd, img_addr, dp_rst, pic_data, filt, bias, busy, done, conv_vld, conv_row, conv_sel
    );
endinterface

// File: rtl/conv1_ctrl.sv
// conv1_ctrl: layer-1 convolution frame sequencer driving image fetch, operands and output-row tags
module conv1_ctrl (
    input logic         clk,
    input logic         rst,
    conv1_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t       state_q, state_d;
    logic [4:0]   cnt_q, cnt_d, slot_q, slot_d, tap;
    logic [223:0] pic_q, pic_d;
    logic [15:0]  prm_q [20];
    logic [15:0]  prm_d [20];
    logic         run, wrap, last, fa, fb, vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            slot_q  <= 5'd1;
            pic_q   <= '0;
            for (int i = 0; i < 20; i++) prm_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            pic_q   <= pic_d;
            prm_q   <= prm_d;
        end
    end

    always_comb begin
        run     = state_q == RUN;
        wrap    = cnt_q == 5'd25;
        last    = wrap && slot_q == 5'd30;
        state_d = state_q == IDLE ? (bus.start ? RUN : IDLE) : run ? (last ? DONE : RUN) : IDLE;
        cnt_d   = run && !wrap ? cnt_q + 5'd1 : '0;
        slot_d  = run && !last ? slot_q + {4'd0, wrap} : 5'd1;
        // the row fetched at cnt 24 arrives now; slot 29 rolls into the zero-padding slot
        pic_d   = !run ? '0 : !wrap ? pic_q : slot_q <= 5'd28 ? bus.img_rdata : '0;
        prm_d   = prm_q;
        if (state_q == IDLE && bus.prm_we && bus.prm_addr < 5'd20) prm_d[bus.prm_addr] = bus.prm_wdata;
        fa      = run && cnt_q < 5'd3;
        fb      = run && cnt_q >= 5'd12 && cnt_q < 5'd15;
        tap     = fb ? 5'd9 + (cnt_q - 5'd12) * 5'd3 : cnt_q * 5'd3;
        vld     = run && slot_q >= 5'd3 && (cnt_q == 5'd3 || cnt_q == 5'd15);
    end

    assign bus.dp_rst   = !run;
    assign bus.busy     = state_q != IDLE;
    assign bus.done     = state_q == DONE;
    assign bus.img_rd   = run && cnt_q == 5'd24 && slot_q <= 5'd28;
    assign bus.img_addr = bus.img_rd ? slot_q - 5'd1 : '0;
    assign bus.pic_data = pic_q;
    assign bus.filt     = fa || fb ? {prm_q[tap + 5'd2], prm_q[tap + 5'd1], prm_q[tap]} : '0;
    assign bus.bias     = !run ? '0 : cnt_q < 5'd12 ? prm_q[18] : prm_q[19];
    assign bus.conv_vld = vld;
    assign bus.conv_row = vld ? slot_q - 5'd3 : '0;
    assign bus.conv_sel = vld && cnt_q == 5'd15;
endmodule

// File: tb/tb_conv1_ctrl.sv
// tb_conv1_ctrl: spot-check vector table plus per-cycle comparison against a frame-index reference model
module tb_conv1_ctrl;
    logic clk = 0;
    logic rst = 1;
    conv1_ctrl_if bus();
    conv1_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct packed {
        logic         dp_rst, busy, done, img_rd;
        logic [4:0]   img_addr;
        logic [223:0] pic;
        logic [47:0]  filt;
        logic [15:0]  bias;
        logic         vld;
        logic [4:0]   row;
        logic         sel;
    } outs_t;

    typedef struct {
        int          s, c;
        logic [47:0] filt;
        logic [15:0] bias;
        logic        vld;
        logic [4:0]  row;
        logic        sel, rd;
        logic [4:0]  addr;
        logic [7:0]  pix;
    } vec_t;

    logic [15:0]  prm [20];
    logic [223:0] img [28];
    outs_t        cap [781];
    vec_t         vt [17];
    int           n_cmp = 0, n_bad = 0, fr = 0;

    always @(posedge clk)
        bus.img_rdata <= bus.img_rd ? img[bus.img_addr]
                                    : {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};

    function automatic outs_t act();
        return {bus.dp_rst, bus.busy, bus.done, bus.img_rd, bus.img_addr, bus.pic_data,
                bus.filt, bus.bias, bus.conv_vld, bus.conv_row, bus.conv_sel};
    endfunction

    // t < 0: idle/reset, 0..779: RUN cycle index within the frame, 780: DONE
    function automatic outs_t exp_at(int t);
        outs_t o;
        int s, c;
        o = '0;
        if (t < 0 || t >= 780) begin
            o.dp_rst = 1;
            o.busy = t >= 780;
            o.done = t >= 780;
            return o;
        end
        s = t / 26 + 1;
        c = t % 26;
        o.busy = 1;
        o.img_rd = c == 24 && s <= 28;
        o.img_addr = o.img_rd ? 5'(s - 1) : 5'd0;
        o.pic = (s >= 2 && s <= 29) ? img[s - 2] : '0;
        if (c < 3) o.filt = {prm[3 * c + 2], prm[3 * c + 1], prm[3 * c]};
        else if (c >= 12 && c < 15) o.filt = {prm[3 * c - 25], prm[3 * c - 26], prm[3 * c - 27]};
        o.bias = c < 12 ? prm[18] : prm[19];
        o.vld = s >= 3 && (c == 3 || c == 15);
        o.row = o.vld ? 5'(s - 3) : 5'd0;
        o.sel = o.vld && c == 15;
        return o;
    endfunction

    function automatic vec_t mk(int s, int c, logic [47:0] f, logic [15:0] b, int v, int r, int sl, int rd, int ad, int px);
        vec_t x;
        x.s = s; x.c = c; x.filt = f; x.bias = b;
        x.vld = 1'(v); x.row = 5'(r); x.sel = 1'(sl); x.rd = 1'(rd); x.addr = 5'(ad); x.pix = 8'(px);
        return x;
    endfunction

    task automatic chk(input string nm, input outs_t a, input outs_t e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", nm, a, e);
        end
    endtask

    task automatic chk_i(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        bus.prm_we = 1; bus.prm_addr = a; bus.prm_wdata = d;
        if (a < 5'd20) prm[a] = d;
        @(posedge clk); #1;
        bus.prm_we = 0;
    endtask

    task automatic set_img(input bit idx);
        for (int r = 0; r < 28; r++)
            img[r] = idx ? {28{8'(r)}} : {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic run_frame(input bit junk, input bit we, input logic [4:0] wa, input logic [15:0] wd);
        int np;
        np = 0;
        fr++;
        bus.start = 1; bus.prm_we = we; bus.prm_addr = wa; bus.prm_wdata = wd;
        if (we && wa < 5'd20) prm[wa] = wd;
        @(posedge clk); #1;
        bus.start = 0; bus.prm_we = 0;
        for (int t = 0; t <= 780; t++) begin
            cap[t] = act();
            chk($sformatf("frame%0d t=%0d", fr, t), cap[t], exp_at(t));
            if (cap[t].vld) np++;
            if (junk) begin
                bus.start = 1'($urandom); bus.prm_we = 1'($urandom);
                bus.prm_addr = 5'($urandom); bus.prm_wdata = 16'($urandom);
            end
            if (t == 234) begin
                bus.start = 1; bus.prm_we = 1; bus.prm_addr = 0; bus.prm_wdata = 16'hFFFF;
            end
            @(posedge clk); #1;
            bus.start = 0; bus.prm_we = 0;
        end
        chk($sformatf("frame%0d idle after done", fr), act(), exp_at(-1));
        chk_i($sformatf("frame%0d pulse count", fr), np, 56);
    endtask

    initial begin
        bus.start = 0; bus.prm_we = 0; bus.prm_addr = 0; bus.prm_wdata = 0;
        for (int i = 0; i < 20; i++) prm[i] = '0;
        #2 rst = 0;
        @(posedge clk); #1;
        chk("in reset", act(), exp_at(-1));
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        chk("idle after reset", act(), exp_at(-1));

        // taps A = 1..9, B = 10..18, biases 0x10/0x20, row-index image, then a write to an unused address
        for (int i = 0; i < 18; i++) wr(5'(i), 16'(i + 1));
        wr(5'd18, 16'h0010);
        wr(5'd19, 16'h0020);
        wr(5'd25, 16'hBEEF);
        set_img(1);
        run_frame(0, 0, 5'd0, 16'h0);

        vt[0]  = mk(1, 0, 48'h0003_0002_0001, 16'h0010, 0, 0, 0, 0, 0, 0);
        vt[1]  = mk(5, 0, 48'h0003_0002_0001, 16'h0010, 0, 0, 0, 0, 0, 3);
        vt[2]  = mk(5, 1, 48'h0006_0005_0004, 16'h0010, 0, 0, 0, 0, 0, 3);
        vt[3]  = mk(5, 2, 48'h0009_0008_0007, 16'h0010, 0, 0, 0, 0, 0, 3);
        vt[4]  = mk(5, 3, 48'h0, 16'h0010, 1, 2, 0, 0, 0, 3);
        vt[5]  = mk(5, 11, 48'h0, 16'h0010, 0, 0, 0, 0, 0, 3);
        vt[6]  = mk(5, 12, 48'h000C_000B_000A, 16'h0020, 0, 0, 0, 0, 0, 3);
        vt[7]  = mk(5, 14, 48'h0012_0011_0010, 16'h0020, 0, 0, 0, 0, 0, 3);
        vt[8]  = mk(5, 15, 48'h0, 16'h0020, 1, 2, 1, 0, 0, 3);
        vt[9]  = mk(1, 24, 48'h0, 16'h0020, 0, 0, 0, 1, 0, 0);
        vt[10] = mk(2, 24, 48'h0, 16'h0020, 0, 0, 0, 1, 1, 0);
        vt[11] = mk(28, 24, 48'h0, 16'h0020, 0, 0, 0, 1, 27, 26);
        vt[12] = mk(29, 24, 48'h0, 16'h0020, 0, 0, 0, 0, 0, 27);
        vt[13] = mk(6, 7, 48'h0, 16'h0010, 0, 0, 0, 0, 0, 4);
        vt[14] = mk(30, 15, 48'h0, 16'h0020, 1, 27, 1, 0, 0, 0);
        vt[15] = mk(3, 3, 48'h0, 16'h0010, 1, 0, 0, 0, 0, 1);
        vt[16] = mk(2, 3, 48'h0, 16'h0010, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            outs_t a;
            a = cap[(vt[i].s - 1) * 26 + vt[i].c];
            n_cmp++;
            if ({a.filt, a.bias, a.vld, a.row, a.sel, a.img_rd, a.img_addr, a.pic} !==
                {vt[i].filt, vt[i].bias, vt[i].vld, vt[i].row, vt[i].sel, vt[i].rd, vt[i].addr, {28{vt[i].pix}}}) begin
                n_bad++;
                $display("FAIL vec%0d s=%0d c=%0d got filt=%h bias=%h vld=%b row=%0d sel=%b rd=%b addr=%0d pix=%h exp filt=%h bias=%h vld=%b row=%0d sel=%b rd=%b addr=%0d pix=%h",
                         i, vt[i].s, vt[i].c, a.filt, a.bias, a.vld, a.row, a.sel, a.img_rd, a.img_addr, a.pic[7:0],
                         vt[i].filt, vt[i].bias, vt[i].vld, vt[i].row, vt[i].sel, vt[i].rd, vt[i].addr, vt[i].pix);
            end
        end

        // start together with a bias write, random image, random ignored requests during the frame
        set_img(0);
        run_frame(1, 1, 5'd18, 16'h0055);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 20; i++) wr(5'(i), 16'($urandom));
            set_img(0);
            run_frame(1, 1, 5'($urandom_range(0, 31)), 16'($urandom));
        end

        // asynchronous reset at slot 15 cnt 7, then a clean frame with cleared parameters
        bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        for (int t = 0; t < 371; t++) begin
            chk($sformatf("pre-reset t=%0d", t), act(), exp_at(t));
            @(posedge clk); #1;
        end
        chk("at slot15 cnt7", act(), exp_at(371));
        rst = 0;
        #1;
        chk("async reset immediate", act(), exp_at(-1));
        for (int i = 0; i < 20; i++) prm[i] = '0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("held in reset", act(), exp_at(-1));
        end
        rst = 1;
        @(posedge clk); #1;
        chk("idle after mid-frame reset", act(), exp_at(-1));
        set_img(0);
        run_frame(0, 0, 5'd0, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
